maquina_emissor: RTL and testbench
==================================

MAQUINA_EMISSOR -- requirements
Module: maquina_emissor

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; clock is the only clock, reset_n the only reset.
REQ-002 SHALL have parameter TIMEOUT, default 15, the number of ESPERA_DADO cycles before the message is reissued.
REQ-003 Ports, with name, direction, width and meaning:
- clock, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous reset, active low.
- cpu_valid, in, 1: CPU request present; sampled only in OCIOSO.
- cpu_op, in, 1: 0 = read, 1 = write.
- hit, in, 1: tag match for the addressed line.
- estado_atual, in, 2: MSI state of the addressed or victim line.
- bus_grant, in, 1: bus arbiter grant.
- mem_ready, in, 1: writeback accepted, or miss data returned.
- abort_mem, in, 1: a remote cache supplied the data for this miss.
- bus_req, out, 1: bus ownership request.
- msg_valid, out, 1: one-cycle strobe qualifying mensagem.
- mensagem, out, 2: message code (see REQ-005).
- write_back, out, 1: victim writeback in progress.
- novo_estado, out, 2: next line state.
- estado_we, out, 1: one-cycle line-state write strobe.
- cpu_ready, out, 1: one-cycle request completion.
- ocupado, out, 1: high whenever the FSM is not in OCIOSO.

Function
REQ-004 Line states SHALL be encoded invalido=00, modificado=01, compartilhado=10.
REQ-005 Messages SHALL be encoded invalidar=00, readMiss=01, writeMiss=10, semMensagem=11; mensagem SHALL equal semMensagem whenever msg_valid=0.
REQ-006 FSM states SHALL be OCIOSO, PEDE_BARRAMENTO, WRITEBACK, ENVIA_MSG, ESPERA_DADO, CONCLUI.
REQ-007 A hit SHALL mean hit=1 and estado_atual!=invalido; anything else is a miss.
REQ-008 From OCIOSO with cpu_valid=1:
- Read hit, or write hit with estado_atual=modificado: go to CONCLUI without touching the bus.
- Write hit with estado_atual=compartilhado: message invalidar, final state modificado.
- Read miss: message readMiss, final state compartilhado.
- Write miss: message writeMiss, final state modificado.
- Every non-silent case goes to PEDE_BARRAMENTO.
REQ-009 On a miss with estado_atual=modificado, the victim is dirty; a dirty flag SHALL be registered.
REQ-010 The message, final state and dirty flag SHALL be registered in OCIOSO and held until CONCLUI.
REQ-011 PEDE_BARRAMENTO SHALL assert bus_req until bus_grant=1, then go to WRITEBACK if dirty, else to ENVIA_MSG.
REQ-012 bus_req SHALL stay high from PEDE_BARRAMENTO through CONCLUI inclusive; bus_grant deassertion after the grant SHALL be ignored.
REQ-013 WRITEBACK SHALL hold write_back=1 until mem_ready=1, then go to ENVIA_MSG.
REQ-014 ENVIA_MSG SHALL drive msg_valid=1 for exactly one cycle with the registered message, then go to CONCLUI for invalidar, else to ESPERA_DADO.
REQ-015 ESPERA_DADO SHALL go to CONCLUI on mem_ready=1 or abort_mem=1; both asserted together SHALL count as one completion.
REQ-016 In ESPERA_DADO, a 4-bit counter SHALL count cycles without a response; on reaching TIMEOUT it SHALL clear and return to ENVIA_MSG to reissue the message. The number of retries is unbounded.
REQ-017 CONCLUI SHALL assert estado_we=1, novo_estado=final state and cpu_ready=1 for one cycle, then go to OCIOSO.
- Silent hits SHALL write novo_estado=estado_atual.
REQ-018 cpu_valid SHALL be ignored outside OCIOSO; a request is never lost or duplicated.
REQ-019 A silent hit sampled at edge N SHALL give cpu_ready=1 in cycle N+1.
REQ-020 Write on compartilhado with bus_grant already high, sampled at edge N: msg_valid in cycle N+2, cpu_ready in cycle N+3.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 reset_n=0 SHALL asynchronously force OCIOSO; bus_req, msg_valid, write_back, estado_we, cpu_ready and ocupado to 0; mensagem=semMensagem; novo_estado=invalido; timeout counter and dirty flag cleared.
REQ-023 Reset mid-transaction SHALL abandon the transaction with no estado_we and no cpu_ready; the first request after release SHALL be sampled normally.

Structure
REQ-024 The state codes, message codes and CPU op codes SHALL live in shared package coerencia_pkg, used by this block and the receiver-side machine.
REQ-025 The FSM and counter SHALL be a single module; no sub-module is needed.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Read, hit=1, estado_atual=compartilhado -> cpu_ready one cycle later, novo_estado=10, bus_req never asserted.
- Write, hit=1, estado_atual=compartilhado, bus_grant delayed 3 cycles -> bus_req for 3 cycles, then msg_valid with mensagem=00, then estado_we with novo_estado=01.
- Read, hit=0, estado_atual=modificado -> write_back held until mem_ready, then mensagem=01, abort_mem completes, novo_estado=10.
- Write miss with no response for 15 cycles -> mensagem=10 reissued, then mem_ready -> novo_estado=01, single cpu_ready.
- reset_n pulsed low in ESPERA_DADO -> all outputs 0 immediately, mensagem=11, no cpu_ready.
- mem_ready and abort_mem high in the same cycle -> exactly one estado_we and one cpu_ready.

Source files
------------

// File: rtl/coerencia_pkg.sv
// Shared MSI coherence encodings for the sender- and receiver-side controllers.
// Line states, bus message codes and CPU operation codes.
package coerencia_pkg;

    typedef enum logic [1:0] {
        INVALIDO      = 2'b00,
        MODIFICADO    = 2'b01,
        COMPARTILHADO = 2'b10
    } estado_linha_t;

    typedef enum logic [1:0] {
        INVALIDAR    = 2'b00,
        READ_MISS    = 2'b01,
        WRITE_MISS   = 2'b10,
        SEM_MENSAGEM = 2'b11
    } mensagem_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } cpu_op_t;

    // A tag match on an invalid line is still a miss.
    function automatic logic eh_hit(input logic hit, input logic [1:0] estado);
        return hit && (estado != INVALIDO);
    endfunction

endpackage

// File: rtl/maquina_emissor.sv
// Sender-side MSI controller: turns a CPU request into bus messages, optional
// victim writeback and a final line-state update, with timed message reissue.
module maquina_emissor
    import coerencia_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cpu_valid,
    input  logic       cpu_op,
    input  logic       hit,
    input  logic [1:0] estado_atual,
    input  logic       bus_grant,
    input  logic       mem_ready,
    input  logic       abort_mem,
    output logic       bus_req,
    output logic       msg_valid,
    output logic [1:0] mensagem,
    output logic       write_back,
    output logic [1:0] novo_estado,
    output logic       estado_we,
    output logic       cpu_ready,
    output logic       ocupado
);

    localparam logic [2:0] OCIOSO          = 3'd0;
    localparam logic [2:0] PEDE_BARRAMENTO = 3'd1;
    localparam logic [2:0] WRITEBACK       = 3'd2;
    localparam logic [2:0] ENVIA_MSG       = 3'd3;
    localparam logic [2:0] ESPERA_DADO     = 3'd4;
    localparam logic [2:0] CONCLUI         = 3'd5;

    localparam logic [3:0] ULTIMA_ESPERA = 4'(TIMEOUT - 1);

    logic [2:0]    estado, estado_prox;
    mensagem_t     msg_reg, msg_prox;
    estado_linha_t final_reg, final_prox;
    logic          sujo_reg, sujo_prox;
    logic          silencioso_reg, silencioso_prox;
    logic [3:0]    contador, contador_prox;
    logic          acerto, escrita;

    assign acerto  = eh_hit(hit, estado_atual);
    assign escrita = (cpu_op == OP_WRITE);

    always_comb begin
        estado_prox     = estado;
        msg_prox        = msg_reg;
        final_prox      = final_reg;
        sujo_prox       = sujo_reg;
        silencioso_prox = silencioso_reg;
        contador_prox   = contador;

        case (estado)
            OCIOSO: begin
                contador_prox = '0;
                if (cpu_valid) begin
                    sujo_prox       = !acerto && (estado_atual == MODIFICADO);
                    silencioso_prox = acerto && (!escrita || estado_atual == MODIFICADO);
                    if (silencioso_prox) begin
                        msg_prox    = SEM_MENSAGEM;
                        final_prox  = estado_linha_t'(estado_atual);
                        estado_prox = CONCLUI;
                    end else begin
                        if (acerto) begin
                            msg_prox   = INVALIDAR;
                            final_prox = MODIFICADO;
                        end else if (!escrita) begin
                            msg_prox   = READ_MISS;
                            final_prox = COMPARTILHADO;
                        end else begin
                            msg_prox   = WRITE_MISS;
                            final_prox = MODIFICADO;
                        end
                        estado_prox = PEDE_BARRAMENTO;
                    end
                end
            end
            PEDE_BARRAMENTO: begin
                if (bus_grant) begin
                    estado_prox = sujo_reg ? WRITEBACK : ENVIA_MSG;
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    estado_prox = ENVIA_MSG;
                end
            end
            ENVIA_MSG: begin
                contador_prox = '0;
                estado_prox   = (msg_reg == INVALIDAR) ? CONCLUI : ESPERA_DADO;
            end
            ESPERA_DADO: begin
                if (mem_ready || abort_mem) begin
                    contador_prox = '0;
                    estado_prox   = CONCLUI;
                end else if (contador == ULTIMA_ESPERA) begin
                    contador_prox = '0;
                    estado_prox   = ENVIA_MSG;
                end else begin
                    contador_prox = contador + 4'd1;
                end
            end
            CONCLUI: begin
                estado_prox = OCIOSO;
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in the
    // same cycle the FSM enters that state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado         <= OCIOSO;
            msg_reg        <= SEM_MENSAGEM;
            final_reg      <= INVALIDO;
            sujo_reg       <= 1'b0;
            silencioso_reg <= 1'b0;
            contador       <= '0;
            bus_req        <= 1'b0;
            msg_valid      <= 1'b0;
            mensagem       <= SEM_MENSAGEM;
            write_back     <= 1'b0;
            novo_estado    <= INVALIDO;
            estado_we      <= 1'b0;
            cpu_ready      <= 1'b0;
            ocupado        <= 1'b0;
        end else begin
            estado         <= estado_prox;
            msg_reg        <= msg_prox;
            final_reg      <= final_prox;
            sujo_reg       <= sujo_prox;
            silencioso_reg <= silencioso_prox;
            contador       <= contador_prox;
            bus_req        <= (estado_prox != OCIOSO) && !silencioso_prox;
            msg_valid      <= (estado_prox == ENVIA_MSG);
            mensagem       <= (estado_prox == ENVIA_MSG) ? msg_prox : SEM_MENSAGEM;
            write_back     <= (estado_prox == WRITEBACK);
            novo_estado    <= (estado_prox == CONCLUI) ? final_prox : INVALIDO;
            estado_we      <= (estado_prox == CONCLUI);
            cpu_ready      <= (estado_prox == CONCLUI);
            ocupado        <= (estado_prox != OCIOSO);
        end
    end

endmodule

// File: tb/tb_maquina_emissor.sv
// Directed bench for maquina_emissor: expected messages and final line states
// are queued at request time and consumed by a monitor as the DUT emits them.
module tb_maquina_emissor;
    import coerencia_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cpu_valid, cpu_op, hit, bus_grant, mem_ready, abort_mem;
    logic [1:0] estado_atual;
    logic       bus_req, msg_valid, write_back, estado_we, cpu_ready, ocupado;
    logic [1:0] mensagem, novo_estado;

    int vectors = 0;
    int miscompares = 0;
    int cnt_ready = 0, cnt_we = 0, cnt_msg = 0, cnt_bus = 0;
    int r0, w0, m0, b0;

    logic [1:0] exp_msg_q[$];
    logic [1:0] exp_estado_q[$];

    always #5 clock = ~clock;

    maquina_emissor #(.TIMEOUT(15)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_valid(cpu_valid), .cpu_op(cpu_op), .hit(hit), .estado_atual(estado_atual),
        .bus_grant(bus_grant), .mem_ready(mem_ready), .abort_mem(abort_mem),
        .bus_req(bus_req), .msg_valid(msg_valid), .mensagem(mensagem),
        .write_back(write_back), .novo_estado(novo_estado), .estado_we(estado_we),
        .cpu_ready(cpu_ready), .ocupado(ocupado)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic op, input logic h, input logic [1:0] est);
        cpu_valid    = 1'b1;
        cpu_op       = op;
        hit          = h;
        estado_atual = est;
        tick();
        cpu_valid    = 1'b0;
    endtask

    task automatic snap();
        r0 = cnt_ready; w0 = cnt_we; m0 = cnt_msg; b0 = cnt_bus;
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus_req)   cnt_bus++;
            if (estado_we) cnt_we++;
            if (msg_valid) begin
                cnt_msg++;
                if (exp_msg_q.size() == 0) begin
                    vectors++; miscompares++;
                    $error("FAIL msg_spurious observed=%0h expected=none", mensagem);
                end else begin
                    chk("mensagem", 32'(mensagem), 32'(exp_msg_q.pop_front()));
                end
            end
            if (cpu_ready) begin
                cnt_ready++;
                if (exp_estado_q.size() == 0) begin
                    vectors++; miscompares++;
                    $error("FAIL ready_spurious observed=%0h expected=none", novo_estado);
                end else begin
                    chk("novo_estado", 32'(novo_estado), 32'(exp_estado_q.pop_front()));
                    chk("we_with_ready", 32'(estado_we), 1);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; cpu_valid = 1'b0; cpu_op = 1'b0; hit = 1'b0;
        estado_atual = 2'b00; bus_grant = 1'b0; mem_ready = 1'b0; abort_mem = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(ocupado), 0);
        chk("rst_msg", 32'(mensagem), 32'(SEM_MENSAGEM));
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_ready", 32'(cpu_ready), 0);
        reset_n = 1'b1;
        tick();

        // Silent read hit on a shared line
        snap();
        exp_estado_q.push_back(COMPARTILHADO);
        issue(OP_READ, 1'b1, COMPARTILHADO);
        chk("s1_ready", 32'(cpu_ready), 1);
        chk("s1_novo", 32'(novo_estado), 32'(COMPARTILHADO));
        chk("s1_bus_req", 32'(bus_req), 0);
        tick();
        chk("s1_idle", 32'(ocupado), 0);
        chk("s1_bus_cnt", 32'(cnt_bus - b0), 0);

        // Write hit on shared line, grant arrives after 3 cycles of request
        snap();
        bus_grant = 1'b0;
        exp_msg_q.push_back(INVALIDAR);
        exp_estado_q.push_back(MODIFICADO);
        issue(OP_WRITE, 1'b1, COMPARTILHADO);
        chk("s2_req1", 32'(bus_req), 1);
        tick();
        chk("s2_req2", 32'(bus_req), 1);
        tick();
        bus_grant = 1'b1;
        chk("s2_req3", 32'(bus_req), 1);
        chk("s2_nomsg", 32'(msg_valid), 0);
        tick();
        bus_grant = 1'b0;
        chk("s2_msg", 32'(msg_valid), 1);
        chk("s2_msg_code", 32'(mensagem), 32'(INVALIDAR));
        tick();
        chk("s2_we", 32'(estado_we), 1);
        chk("s2_novo", 32'(novo_estado), 32'(MODIFICADO));
        chk("s2_bus_hold", 32'(bus_req), 1);
        tick();
        chk("s2_bus_cnt", 32'(cnt_bus - b0), 5);
        chk("s2_bus_off", 32'(bus_req), 0);

        // Read miss with dirty victim: writeback, readMiss, remote abort
        bus_grant = 1'b1;
        snap();
        exp_msg_q.push_back(READ_MISS);
        exp_estado_q.push_back(COMPARTILHADO);
        issue(OP_READ, 1'b0, MODIFICADO);
        chk("s3_wb0", 32'(write_back), 0);
        tick();
        chk("s3_wb1", 32'(write_back), 1);
        chk("s3_msg_idle", 32'(mensagem), 32'(SEM_MENSAGEM));
        tick();
        chk("s3_wb2", 32'(write_back), 1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("s3_msg", 32'(msg_valid), 1);
        chk("s3_wb_off", 32'(write_back), 0);
        tick();
        abort_mem = 1'b1;
        tick();
        abort_mem = 1'b0;
        chk("s3_ready", 32'(cpu_ready), 1);
        chk("s3_novo", 32'(novo_estado), 32'(COMPARTILHADO));
        tick();

        // Write miss, no response for 15 cycles -> reissue, then mem_ready
        snap();
        exp_msg_q.push_back(WRITE_MISS);
        exp_msg_q.push_back(WRITE_MISS);
        exp_estado_q.push_back(MODIFICADO);
        issue(OP_WRITE, 1'b0, INVALIDO);
        tick();
        chk("s4_msg1", 32'(msg_valid), 1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("s4_wait_nomsg", 32'(msg_valid), 0);
        end
        tick();
        chk("s4_reissue", 32'(msg_valid), 1);
        chk("s4_reissue_code", 32'(mensagem), 32'(WRITE_MISS));
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("s4_ready", 32'(cpu_ready), 1);
        tick(); tick();
        chk("s4_ready_cnt", 32'(cnt_ready - r0), 1);
        chk("s4_msg_cnt", 32'(cnt_msg - m0), 2);

        // Reset asserted while waiting for data
        snap();
        exp_msg_q.push_back(READ_MISS);
        issue(OP_READ, 1'b0, INVALIDO);
        tick(); tick(); tick();
        chk("s5_busy", 32'(ocupado), 1);
        reset_n = 1'b0;
        #1;
        chk("s5_busy_rst", 32'(ocupado), 0);
        chk("s5_bus_rst", 32'(bus_req), 0);
        chk("s5_msg_rst", 32'(mensagem), 32'(SEM_MENSAGEM));
        chk("s5_novo_rst", 32'(novo_estado), 32'(INVALIDO));
        tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("s5_no_ready", 32'(cnt_ready - r0), 0);
        chk("s5_no_we", 32'(cnt_we - w0), 0);

        // mem_ready and abort_mem together: one completion only
        snap();
        exp_msg_q.push_back(READ_MISS);
        exp_estado_q.push_back(COMPARTILHADO);
        issue(OP_READ, 1'b0, INVALIDO);
        tick(); tick();
        mem_ready = 1'b1; abort_mem = 1'b1;
        tick();
        mem_ready = 1'b0; abort_mem = 1'b0;
        chk("s6_ready", 32'(cpu_ready), 1);
        tick(); tick();
        chk("s6_ready_cnt", 32'(cnt_ready - r0), 1);
        chk("s6_we_cnt", 32'(cnt_we - w0), 1);

        // Grant already high: msg at N+2, ready at N+3; cpu_valid held high
        snap();
        bus_grant = 1'b1;
        exp_msg_q.push_back(INVALIDAR);
        exp_estado_q.push_back(MODIFICADO);
        cpu_valid = 1'b1; cpu_op = OP_WRITE; hit = 1'b1; estado_atual = COMPARTILHADO;
        tick();
        chk("s7_n1_msg", 32'(msg_valid), 0);
        tick();
        chk("s7_n2_msg", 32'(msg_valid), 1);
        tick();
        cpu_valid = 1'b0;
        chk("s7_n3_ready", 32'(cpu_ready), 1);
        tick(); tick();
        chk("s7_ready_cnt", 32'(cnt_ready - r0), 1);
        chk("s7_idle", 32'(ocupado), 0);

        // Silent write hit on a modified line
        snap();
        exp_estado_q.push_back(MODIFICADO);
        issue(OP_WRITE, 1'b1, MODIFICADO);
        chk("s8_ready", 32'(cpu_ready), 1);
        chk("s8_bus_req", 32'(bus_req), 0);
        tick();

        chk("msg_q_empty", 32'(exp_msg_q.size()), 0);
        chk("estado_q_empty", 32'(exp_estado_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
